reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter and write sequencer sharing one bank of 16-bit negedge-capture enable registers (PE scratch/config registers) between several requesters.
- Accepts one write per clock via valid/ready.
- Drives a one-hot enable vector and a shared data bus from posedge flops, so both are stable at the following negedge capture.
- Supports short locked bursts so one requester can own the bank for consecutive writes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_REGS, 8, number of target registers in the bank
- ADDR_W, 3, register address width per requester; must satisfy 2^ADDR_W >= NUM_REGS
- DATA_W, 16, data width
- MAX_LOCK, 4, maximum consecutive locked transfers before forced release (1..15)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester write request
- req_lock  input  NUM_REQ  request to keep the grant after this transfer
- req_addr  input  NUM_REQ*ADDR_W  packed target addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot grant, combinational from state and req_valid
- reg_en  output  NUM_REGS  registered one-hot enable to the register bank
- reg_d  output  DATA_W  registered write data to the register bank
- grant_id  output  3  registered index of the last granted requester
- err_addr  output  1  registered one-cycle pulse for an out-of-range address
- busy  output  1  high while in the LOCKED state

Behaviour:
- Reset (async, rst_n=0): reg_en=0, reg_d=0, grant_id=0, err_addr=0, busy=0, state=ARB, rr_ptr=0, lock_cnt=0.
  - reg_en clears immediately on reset, so no register captures at the next negedge.
- Transfer: occurs at a posedge when req_valid[i] && req_ready[i]. At most one req_ready bit is high per cycle. req_ready never asserts without the matching req_valid.
- State ARB: grant the first valid requester scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - On a transfer by i with req_lock[i]=0: rr_ptr <= (i+1) mod NUM_REQ; stay in ARB.
  - On a transfer by i with req_lock[i]=1: owner <= i, lock_cnt <= 1, go to LOCKED.
  - If MAX_LOCK=1, a locked transfer behaves as unlocked.
- State LOCKED: only the owner may be granted; other requesters see ready=0.
  - Owner transfer with lock=1: lock_cnt increments. When lock_cnt reaches MAX_LOCK after this transfer, exit to ARB with rr_ptr <= owner+1 (forced release).
  - Owner transfer with lock=0: exit to ARB with rr_ptr <= owner+1.
  - Owner req_valid=0: exit to ARB the next cycle with rr_ptr <= owner+1, no transfer. An idle owner never stalls the bank.
- Output timing, on the posedge of a transfer:
  - reg_d <= the granted requester's data.
  - reg_en <= onehot(addr) if addr < NUM_REGS, otherwise all zero with err_addr <= 1.
  - grant_id <= i.
  - The register bank captures on the following negedge, so end-to-end latency is half a cycle from the accepting posedge.
- No transfer: reg_en <= 0 and err_addr <= 0. reg_d and grant_id hold their values.
- busy = (state == LOCKED).
- Back-to-back transfers produce consecutive reg_en pulses, each exactly one cycle wide.
- A requester's address, data and lock must be stable while its valid is high. Dropping valid without a transfer is allowed.

Optional Feature:
- Macro: REG_ARB_CONTENTION_CNT_EN.
- Defined:
  - Adds output contention_cnt, 16 bits.
  - Increments (saturating at 16'hFFFF) on every cycle in which a valid requester is not granted.
  - Reset value 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single write: req_valid=4'b0001, addr0=3, data0=16'hBEEF, lock=0 -> ready=0001 for one cycle; reg_en=8'h08 for one cycle; reg_d=BEEF; register 3 holds BEEF after the next negedge.
- Round robin: all four valid continuously, no lock -> grant order 0,1,2,3,0,1; grant_id follows the same sequence; each ready is one-hot.
- Lock burst: requester 2 valid with lock=1 for 6 cycles, requesters 0/1 also valid -> requester 2 gets 4 transfers (MAX_LOCK), busy=1 throughout the burst, then requester 3 or 0 is granted by the rr_ptr=3 scan (0 if 3 is idle).
- Out of range: NUM_REGS=6, addr=7 -> transfer accepted, reg_en=0, err_addr=1 for exactly one cycle.
- Owner drops valid during LOCKED -> returns to ARB the next cycle, busy=0, another requester granted the following cycle.
- Reset mid-burst: rst_n low while in LOCKED with reg_en=8'h01 -> reg_en=0 and busy=0 immediately; after release, requester 0 has priority (rr_ptr=0).

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter with short locked bursts, driving a negedge-capture register bank.
// Define REG_ARB_CONTENTION_CNT_EN to add a saturating contention_cnt output.
module reg_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REGS-1:0]       reg_en,
  output logic [DATA_W-1:0]         reg_d,
  output logic [2:0]                grant_id,
  output logic                      err_addr,
`ifdef REG_ARB_CONTENTION_CNT_EN
  output logic [15:0]               contention_cnt,
`endif
  output logic                      busy
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [2:0]          owner_q, owner_d;
  logic [3:0]          lock_cnt_q, lock_cnt_d;
  logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
  logic [DATA_W-1:0]   reg_d_q, reg_d_d;
  logic [2:0]          grant_id_q, grant_id_d;
  logic                err_addr_q, err_addr_d;

  logic [7:0]          valid_pad;
  logic                gnt_found;
  logic [2:0]          gnt_idx;
  logic [3:0]          cand_sum;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_lock;

  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx == 3'(NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  assign valid_pad = 8'(req_valid);

  // Locked: only the owner can win; otherwise first valid requester from rr_ptr upward.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    if (state_q == LOCKED) begin
      gnt_found = valid_pad[owner_q];
      gnt_idx   = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_sum = {1'b0, rr_ptr_q} + 4'(k);
        if (cand_sum >= 4'(NUM_REQ)) cand_sum = cand_sum - 4'(NUM_REQ);
        if (!gnt_found && valid_pad[cand_sum[2:0]]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand_sum[2:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_lock  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && gnt_idx == 3'(i)) begin
        req_ready[i] = 1'b1;
        sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
        sel_data     = req_data[i*DATA_W +: DATA_W];
        sel_lock     = req_lock[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    reg_en_d   = '0;
    err_addr_d = 1'b0;
    reg_d_d    = reg_d_q;
    grant_id_d = grant_id_q;

    if (gnt_found) begin
      reg_d_d    = sel_data;
      grant_id_d = gnt_idx;
      if ({1'b0, sel_addr} < (ADDR_W+1)'(NUM_REGS)) begin
        for (int r = 0; r < NUM_REGS; r++) reg_en_d[r] = (sel_addr == ADDR_W'(r));
      end else begin
        err_addr_d = 1'b1;
      end
    end

    // Any LOCKED cycle without a continuing locked transfer releases the bank.
    if (state_q == ARB) begin
      if (gnt_found) begin
        if (sel_lock && MAX_LOCK > 1) begin
          state_d    = LOCKED;
          owner_d    = gnt_idx;
          lock_cnt_d = 4'd1;
        end else begin
          rr_ptr_d = next_idx(gnt_idx);
        end
      end
    end else begin
      if (gnt_found && sel_lock && (lock_cnt_q + 4'd1) < 4'(MAX_LOCK)) begin
        lock_cnt_d = lock_cnt_q + 4'd1;
      end else begin
        state_d    = ARB;
        rr_ptr_d   = next_idx(owner_q);
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      reg_en_q   <= '0;
      reg_d_q    <= '0;
      grant_id_q <= '0;
      err_addr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      reg_en_q   <= reg_en_d;
      reg_d_q    <= reg_d_d;
      grant_id_q <= grant_id_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign reg_en   = reg_en_q;
  assign reg_d    = reg_d_q;
  assign grant_id = grant_id_q;
  assign err_addr = err_addr_q;
  assign busy     = (state_q == LOCKED);

`ifdef REG_ARB_CONTENTION_CNT_EN
  logic [15:0] contention_cnt_q, contention_cnt_d;

  always_comb begin
    contention_cnt_d = contention_cnt_q;
    if (|(req_valid & ~req_ready) && contention_cnt_q != 16'hFFFF)
      contention_cnt_d = contention_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) contention_cnt_q <= '0;
    else        contention_cnt_q <= contention_cnt_d;
  end

  assign contention_cnt = contention_cnt_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and randomized bench for reg_write_arbiter, checked against a rule-level model.
module tb_reg_write_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int NUM_REGS = 6;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 16;
  localparam int MAX_LOCK = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [ADDR_W-1:0]         addrA [NUM_REQ];
  logic [DATA_W-1:0]         dataA [NUM_REQ];
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REGS-1:0]       reg_en;
  logic [DATA_W-1:0]         reg_d;
  logic [2:0]                grant_id;
  logic                      err_addr;
  logic                      busy;
`ifdef REG_ARB_CONTENTION_CNT_EN
  logic [15:0]               contention_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Model state, expressed in terms of the arbitration rules.
  int                  mPtr, mOwner, mCnt, mCont;
  bit                  mLocked;
  logic [NUM_REGS-1:0] mRegEn;
  logic [DATA_W-1:0]   mRegD;
  logic [2:0]          mGrant;
  logic                mErr;

  logic [DATA_W-1:0]   bank [NUM_REGS];

  reg_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_lock      (req_lock),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .reg_en        (reg_en),
    .reg_d         (reg_d),
    .grant_id      (grant_id),
    .err_addr      (err_addr),
`ifdef REG_ARB_CONTENTION_CNT_EN
    .contention_cnt(contention_cnt),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = addrA[i];
      req_data[i*DATA_W +: DATA_W] = dataA[i];
    end
  end

  // Register bank that captures on the falling edge.
  always @(negedge clk) begin
    for (int r = 0; r < NUM_REGS; r++)
      if (reg_en[r]) bank[r] <= reg_d;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bitOf(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  function automatic int modelPick(input logic [3:0] v);
    if (mLocked) return bitOf(v, mOwner) ? mOwner : -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (bitOf(v, (mPtr + k) % NUM_REQ)) return (mPtr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic resetModel();
    mPtr = 0; mOwner = 0; mCnt = 0; mCont = 0; mLocked = 1'b0;
    mRegEn = '0; mRegD = '0; mGrant = '0; mErr = 1'b0;
  endtask

  // One clock: drive after the negedge, check ready mid-cycle, check registered outputs after the posedge.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] lk, output int g);
    logic [3:0]        expReady;
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    req_valid = v;
    req_lock  = lk;
    #1;
    g = modelPick(v);
    expReady = (g >= 0) ? (4'd1 << g) : 4'd0;
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    @(posedge clk);
    #1;
    if ((v & ~expReady) != 4'd0 && mCont < 65535) mCont++;
    if (g >= 0) begin
      a      = addrA[g];
      mRegD  = dataA[g];
      mGrant = 3'(g);
      if (int'(a) < NUM_REGS) begin
        mRegEn = 6'd1 << a;
        mErr   = 1'b0;
      end else begin
        mRegEn = '0;
        mErr   = 1'b1;
      end
      if (!mLocked) begin
        if (bitOf(lk, g) && MAX_LOCK > 1) begin
          mLocked = 1'b1; mOwner = g; mCnt = 1;
        end else begin
          mPtr = (g + 1) % NUM_REQ;
        end
      end else if (bitOf(lk, g) && mCnt + 1 < MAX_LOCK) begin
        mCnt++;
      end else begin
        mLocked = 1'b0;
        mPtr    = (g + 1) % NUM_REQ;
      end
    end else begin
      mRegEn = '0;
      mErr   = 1'b0;
      if (mLocked) begin
        mLocked = 1'b0;
        mPtr    = (mOwner + 1) % NUM_REQ;
      end
    end
    checkOutput("reg_en",   32'(reg_en),   32'(mRegEn));
    checkOutput("reg_d",    32'(reg_d),    32'(mRegD));
    checkOutput("grant_id", 32'(grant_id), 32'(mGrant));
    checkOutput("err_addr", 32'(err_addr), 32'(mErr));
    checkOutput("busy",     32'(busy),     32'(mLocked));
`ifdef REG_ARB_CONTENTION_CNT_EN
    checkOutput("contention_cnt", 32'(contention_cnt), 32'(mCont));
`endif
  endtask

  initial begin
    int         g;
    int         n2;
    int         rrExp [6];
    int         burstGrant [6];
    logic [3:0] prevV, granted, v, lkR;

    rrExp = '{1, 2, 3, 0, 1, 2};
    rst_n = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      addrA[i] = '0;
      dataA[i] = '0;
    end
    resetModel();
    #2;
    checkOutput("rst_reg_en",   32'(reg_en),    32'h0);
    checkOutput("rst_reg_d",    32'(reg_d),     32'h0);
    checkOutput("rst_grant_id", 32'(grant_id),  32'h0);
    checkOutput("rst_err_addr", 32'(err_addr),  32'h0);
    checkOutput("rst_busy",     32'(busy),      32'h0);
    checkOutput("rst_ready",    32'(req_ready), 32'h0);
    #10 rst_n = 1'b1;

    $display("[TB] single write");
    addrA[0] = 3'd3;
    dataA[0] = 16'hBEEF;
    applyStimulus(4'b0001, 4'b0000, g);
    checkOutput("single_en", 32'(reg_en), 32'h08);
    checkOutput("single_d",  32'(reg_d),  32'hBEEF);
    applyStimulus(4'b0000, 4'b0000, g);
    checkOutput("single_pulse_end", 32'(reg_en), 32'h0);
    checkOutput("bank3", 32'(bank[3]), 32'hBEEF);

    $display("[TB] round robin");
    for (int i = 0; i < NUM_REQ; i++) begin
      addrA[i] = 3'(i);
      dataA[i] = 16'h1000 + 16'(i);
    end
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b1111, 4'b0000, g);
      checkOutput("rr_order", 32'(grant_id), 32'(rrExp[c]));
    end

    $display("[TB] lock burst");
    applyStimulus(4'b0010, 4'b0000, g);
    n2 = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0111, 4'b0100, g);
      burstGrant[c] = int'(grant_id);
      if (grant_id == 3'd2 && reg_en != '0) n2++;
    end
    checkOutput("burst_len",   32'(n2),            32'd4);
    checkOutput("burst_after", 32'(burstGrant[4]), 32'd0);
    applyStimulus(4'b0000, 4'b0000, g);

    $display("[TB] out of range");
    addrA[0] = 3'd7;
    applyStimulus(4'b0001, 4'b0000, g);
    checkOutput("oor_en",  32'(reg_en),   32'h0);
    checkOutput("oor_err", 32'(err_addr), 32'h1);
    applyStimulus(4'b0000, 4'b0000, g);
    checkOutput("oor_err_clear", 32'(err_addr), 32'h0);

    $display("[TB] owner drops valid");
    addrA[3] = 3'd5;
    dataA[3] = 16'h3333;
    addrA[1] = 3'd1;
    applyStimulus(4'b1000, 4'b1000, g);
    checkOutput("drop_busy1", 32'(busy), 32'h1);
    applyStimulus(4'b0010, 4'b1000, g);
    checkOutput("drop_busy0", 32'(busy), 32'h0);
    applyStimulus(4'b0010, 4'b0000, g);
    checkOutput("drop_next", 32'(grant_id), 32'd1);

    $display("[TB] reset mid-burst");
    addrA[0] = 3'd0;
    dataA[0] = 16'hA5A5;
    applyStimulus(4'b0001, 4'b0001, g);
    checkOutput("pre_rst_en", 32'(reg_en), 32'h01);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_en",   32'(reg_en), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy),   32'h0);
    resetModel();
    #1 rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b0000, g);
    checkOutput("post_rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_no_capture", 32'(bank[0]),  32'h1000);
    applyStimulus(4'b0000, 4'b0000, g);

    $display("[TB] random traffic");
    prevV   = '0;
    granted = '0;
    lkR     = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (prevV[i] && !granted[i] && ($urandom_range(7) != 0)) begin
          v[i] = 1'b1;
        end else begin
          v[i]     = ($urandom_range(9) < 6);
          lkR[i]   = 1'($urandom_range(1));
          addrA[i] = ADDR_W'($urandom_range(7));
          dataA[i] = DATA_W'($urandom);
        end
      end
      applyStimulus(v, lkR, g);
      prevV   = v;
      granted = (g >= 0) ? (4'd1 << g) : 4'd0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
